ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter HALT_OP, default 4'hF, meaning the opcode in ir[31:28] that halts fetching.
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_f  input  1  reset: asynchronous, active-high (asserted = 1).
REQ-005 SHALL have port mem_req  output  1  instruction memory read request.
REQ-006 SHALL have port mem_addr  output  16  word address of the request.
REQ-007 SHALL have port mem_ack  input  1  memory returns data this cycle.
REQ-008 SHALL have port mem_rdata  input  32  instruction word, valid when mem_ack=1.
REQ-009 SHALL have port ir  output  32  registered instruction presented to the sisc core.
REQ-010 SHALL have port ir_valid  output  1  ir holds a fetched, unconsumed instruction.
REQ-011 SHALL have port ir_taken  input  1  core consumed ir this cycle (pulse).
REQ-012 SHALL have port br_load  input  1  redirect PC; sampled only with ir_taken.
REQ-013 SHALL have port br_addr  input  16  redirect target.
REQ-014 SHALL have port pc  output  16  address of the instruction in ir.
REQ-015 SHALL have port halted  output  1  HALT_OP fetched; fetching stopped.
REQ-016 SHALL have port fetch_cnt  output  16  count of completed fetches.

Function
REQ-017 SHALL implement states FETCH, HOLD and HALT; after reset the state SHALL be FETCH.
REQ-018 In FETCH: mem_req=1 and mem_addr=next_pc; on mem_ack, the block SHALL capture ir<=mem_rdata and pc<=next_pc, set ir_valid=1 and go to HOLD, all on the same edge.
REQ-019 mem_req and mem_addr SHALL stay stable until mem_ack; the request SHALL NOT be withdrawn.
REQ-020 In HOLD: mem_req=0 and ir/pc SHALL stay stable until ir_taken.
REQ-021 In HOLD, ir_taken with br_load=0 SHALL set next_pc<=pc+1, with 16-bit wrap (16'hFFFF+1 = 16'h0000).
REQ-022 In HOLD, ir_taken with br_load=1 SHALL set next_pc<=br_addr.
REQ-023 On either case of REQ-021/REQ-022, the block SHALL clear ir_valid and go to FETCH; the new request appears on the following cycle, giving 1 bubble cycle minimum.
REQ-024 In HOLD, br_load without ir_taken SHALL be ignored.
REQ-025 ir_taken outside HOLD SHALL be ignored.
REQ-026 If the captured mem_rdata[31:28]==HALT_OP, the block SHALL go to HOLD with ir_valid=1, then on ir_taken go to HALT (not FETCH).
REQ-027 In HALT: halted=1, mem_req=0, ir_valid=0; only reset exits HALT.
REQ-028 fetch_cnt SHALL increment by 1 on each mem_ack accepted in FETCH, wrap at 16'hFFFF->0, and SHALL NOT count in HOLD or HALT.
REQ-029 mem_ack outside FETCH SHALL be ignored and leave ir, pc and fetch_cnt unchanged.
REQ-030 Minimum per-instruction latency SHALL be 1 cycle from request to ir_valid (mem_ack in the same cycle as mem_req).

Reset
REQ-031 While rst_f=1, the block SHALL hold state=FETCH, next_pc=RESET_PC, pc=RESET_PC, ir=0, ir_valid=0, halted=0, fetch_cnt=0 and mem_req=0, irrespective of clk.
REQ-032 Reset asserted mid-request SHALL abandon the request; a mem_ack arriving during reset SHALL be ignored.
REQ-033 The first mem_req after reset SHALL be asserted on the first rising edge after rst_f deasserts, with mem_addr=RESET_PC.

Structure
REQ-034 A shared package SHALL hold the state enum (FETCH/HOLD/HALT), the opcode field position (31:28) and the HALT_OP default, so that ctrl uses the same opcode field definition.
REQ-035 The block SHALL contain one sub-module, pc_reg, holding next_pc with load/increment/reset.
REQ-036 All outputs SHALL be registered except mem_req and mem_addr, which are decoded from state and next_pc.

Verification
REQ-037 Reset, mem_ack tied 1, ir_taken every HOLD cycle -> mem_addr sequence 0,1,2,...; ir_valid alternates 1/0; fetch_cnt increments per fetch.
REQ-038 mem_ack delayed 5 cycles -> mem_req and mem_addr stable for all 5 cycles; ir updates only on the ack edge.
REQ-039 ir_taken with br_load=1 and br_addr=16'h0040 -> next mem_addr=16'h0040; pc=16'h0040 after the ack.
REQ-040 RESET_PC=16'hFFFF, sequential fetch -> second mem_addr=16'h0000.
REQ-041 Fetched word 32'hF0000000 -> ir_valid=1, then after ir_taken halted=1, mem_req stays 0 for 20 cycles, and fetch_cnt is frozen.
REQ-042 rst_f pulsed while mem_req=1, with mem_ack asserted during reset -> all outputs return to reset values; the first post-reset mem_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and the opcode field.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam int         OPC_MSB         = 31;
    localparam int         OPC_LSB         = 28;
    localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

endpackage

// File: rtl/ifetch_pc_reg.sv
// Next-fetch address register: reset to RESET_PC, redirect load, or sequential increment.
module ifetch_pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        i_load,
    input  logic [15:0] i_load_addr,
    input  logic        i_inc,
    output logic [15:0] o_next_pc
);

    logic [15:0] r_next_pc;

    // Load wins over increment; the add wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            r_next_pc <= RESET_PC;
        end else if (i_load) begin
            r_next_pc <= i_load_addr;
        end else if (i_inc) begin
            r_next_pc <= r_next_pc + 16'd1;
        end
    end

    assign o_next_pc = r_next_pc;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: requests one word at a time, holds it in ir until the core takes it.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = HALT_OP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_f,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_taken,
    input  logic        br_load,
    input  logic [15:0] br_addr,
    output logic [15:0] pc,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_armed;
    logic        r_halt_pend;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic [15:0] r_pc;
    logic        r_halted;
    logic [15:0] r_fetch_cnt;
    logic [15:0] w_next_pc;
    logic        w_accept;
    logic        w_take;

    // r_armed keeps the request low until the first edge after reset releases.
    assign w_accept = r_armed && (r_state == ST_FETCH) && mem_ack;
    assign w_take   = (r_state == ST_HOLD) && ir_taken;

    ifetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_f       (rst_f),
        .i_load      (w_take && br_load && !r_halt_pend),
        .i_load_addr (br_addr),
        .i_inc       (w_take && !br_load && !r_halt_pend),
        .o_next_pc   (w_next_pc)
    );

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: if (w_accept) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (ir_taken) w_state_nxt = r_halt_pend ? ST_HALT : ST_FETCH;
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        mem_req  = r_armed && (r_state == ST_FETCH);
        mem_addr = w_next_pc;
    end

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            r_armed     <= 1'b0;
            r_halt_pend <= 1'b0;
            r_ir        <= 32'd0;
            r_ir_valid  <= 1'b0;
            r_pc        <= RESET_PC;
            r_halted    <= 1'b0;
            r_fetch_cnt <= 16'd0;
        end else begin
            r_armed <= 1'b1;
            if (w_accept) begin
                r_ir        <= mem_rdata;
                r_pc        <= w_next_pc;
                r_ir_valid  <= 1'b1;
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
                r_halt_pend <= (mem_rdata[OPC_MSB:OPC_LSB] == HALT_OP);
            end else if (w_take) begin
                r_ir_valid <= 1'b0;
                if (r_halt_pend) r_halted <= 1'b1;
            end
        end
    end

    assign ir        = r_ir;
    assign ir_valid  = r_ir_valid;
    assign pc        = r_pc;
    assign halted    = r_halted;
    assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: cycle-level reference model checked every cycle, plus directed literal checks.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_f = 1'b1;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        ir_taken = 1'b0;
    logic        br_load = 1'b0;
    logic [15:0] br_addr = 16'd0;

    logic        mem_req, ir_valid, halted;
    logic [15:0] mem_addr, pc, fetch_cnt;
    logic [31:0] ir;

    logic        d2_mem_req, d2_ir_valid, d2_halted;
    logic [15:0] d2_mem_addr, d2_pc, d2_fetch_cnt;
    logic [31:0] d2_ir;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ifetch u_dut (
        .clk(clk), .rst_f(rst_f), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
        .ir_taken(ir_taken), .br_load(br_load), .br_addr(br_addr), .pc(pc),
        .halted(halted), .fetch_cnt(fetch_cnt)
    );

    ifetch #(.RESET_PC(16'hFFFF)) u_dut2 (
        .clk(clk), .rst_f(rst_f), .mem_req(d2_mem_req), .mem_addr(d2_mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(d2_ir), .ir_valid(d2_ir_valid),
        .ir_taken(ir_taken), .br_load(br_load), .br_addr(br_addr), .pc(d2_pc),
        .halted(d2_halted), .fetch_cnt(d2_fetch_cnt)
    );

    // Reference model: "holding" means an instruction sits in ir awaiting the core.
    logic        m_armed, m_holding, m_stopped, m_halt_next, m_valid;
    logic [15:0] m_next, m_pc, m_cnt;
    logic [31:0] m_ir;

    function automatic logic m_req();
        return m_armed && !m_holding && !m_stopped;
    endfunction

    always @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            m_armed = 0; m_holding = 0; m_stopped = 0; m_halt_next = 0; m_valid = 0;
            m_next = 16'h0000; m_pc = 16'h0000; m_cnt = 0; m_ir = 0;
        end else begin
            if (m_req() && mem_ack) begin
                m_ir = mem_rdata;
                m_pc = m_next;
                m_valid = 1;
                m_holding = 1;
                m_cnt = m_cnt + 16'd1;
                m_halt_next = (mem_rdata[31:28] == 4'hF);
            end else if (m_holding && ir_taken) begin
                m_holding = 0;
                m_valid = 0;
                if (m_halt_next) m_stopped = 1;
                else m_next = br_load ? br_addr : m_pc + 16'd1;
            end
            m_armed = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("m.mem_req", {31'd0, mem_req}, {31'd0, m_req()});
        if (m_req()) check("m.mem_addr", {16'd0, mem_addr}, {16'd0, m_next});
        check("m.ir", ir, m_ir);
        check("m.ir_valid", {31'd0, ir_valid}, {31'd0, m_valid});
        check("m.pc", {16'd0, pc}, {16'd0, m_pc});
        check("m.halted", {31'd0, halted}, {31'd0, m_stopped});
        check("m.fetch_cnt", {16'd0, fetch_cnt}, {16'd0, m_cnt});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running want done");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check("rst.mem_req", {31'd0, mem_req}, 32'd0);
        check("rst.ir", ir, 32'd0);
        check("rst.pc", {16'd0, pc}, 32'd0);
        check("rst.fetch_cnt", {16'd0, fetch_cnt}, 32'd0);
        check("rst.ir_valid", {31'd0, ir_valid}, 32'd0);

        rst_f = 0;
        step();
        check("first.mem_req", {31'd0, mem_req}, 32'd1);
        check("first.mem_addr", {16'd0, mem_addr}, 32'h0000);
        check("d2.first_addr", {16'd0, d2_mem_addr}, 32'hFFFF);

        // Back-to-back fetches with ack tied high and the core taking every word.
        mem_ack = 1; ir_taken = 1;
        for (int i = 0; i < 8; i++) begin
            mem_rdata = 32'h1000_0000 + i;
            step();
            if (i == 1) begin
                check("d2.second_addr", {16'd0, d2_mem_addr}, 32'h0000);
                check("d2.second_req", {31'd0, d2_mem_req}, 32'd1);
            end
        end
        check("seq.fetch_cnt", {16'd0, fetch_cnt}, 32'd4);
        check("seq.mem_addr", {16'd0, mem_addr}, 32'd4);
        check("seq.ir", ir, 32'h1000_0006);
        check("seq.pc", {16'd0, pc}, 32'd3);

        // Slow memory: request must hold steady while ack is withheld.
        mem_ack = 0; ir_taken = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("wait.mem_req", {31'd0, mem_req}, 32'd1);
            check("wait.mem_addr", {16'd0, mem_addr}, 32'd4);
            check("wait.ir", ir, 32'h1000_0006);
        end
        mem_ack = 1; mem_rdata = 32'h2000_00AA;
        step();
        mem_ack = 0;
        check("ack.ir", ir, 32'h2000_00AA);
        check("ack.pc", {16'd0, pc}, 32'd4);
        check("ack.fetch_cnt", {16'd0, fetch_cnt}, 32'd5);
        check("ack.mem_req", {31'd0, mem_req}, 32'd0);

        // Stray br_load and mem_ack while holding are ignored.
        br_load = 1; br_addr = 16'h1234; mem_ack = 1; mem_rdata = 32'h5555_5555;
        step(); step();
        mem_ack = 0;
        check("hold.pc", {16'd0, pc}, 32'd4);
        check("hold.ir", ir, 32'h2000_00AA);
        check("hold.fetch_cnt", {16'd0, fetch_cnt}, 32'd5);

        // Branch redirect to 0x0040.
        ir_taken = 1; br_load = 1; br_addr = 16'h0040;
        step();
        ir_taken = 0; br_load = 0;
        check("br.ir_valid", {31'd0, ir_valid}, 32'd0);
        check("br.mem_addr", {16'd0, mem_addr}, 32'h0040);
        mem_ack = 1; mem_rdata = 32'h3000_0001;
        step();
        mem_ack = 0;
        check("br.pc", {16'd0, pc}, 32'h0040);
        check("br.fetch_cnt", {16'd0, fetch_cnt}, 32'd6);

        // Sequential wrap from 0xFFFF to 0x0000.
        ir_taken = 1; br_load = 1; br_addr = 16'hFFFF;
        step();
        ir_taken = 0; br_load = 0; mem_ack = 1; mem_rdata = 32'h3000_0002;
        step();
        mem_ack = 0;
        check("wrap.pc", {16'd0, pc}, 32'hFFFF);
        ir_taken = 1;
        step();
        ir_taken = 0;
        check("wrap.mem_addr", {16'd0, mem_addr}, 32'h0000);

        // Halt opcode.
        mem_ack = 1; mem_rdata = 32'hF000_0000;
        step();
        mem_ack = 0;
        check("halt.ir_valid", {31'd0, ir_valid}, 32'd1);
        check("halt.pre_halted", {31'd0, halted}, 32'd0);
        check("halt.fetch_cnt", {16'd0, fetch_cnt}, 32'd8);
        ir_taken = 1;
        step();
        check("halt.halted", {31'd0, halted}, 32'd1);
        check("halt.ir_valid0", {31'd0, ir_valid}, 32'd0);
        mem_ack = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("halt.mem_req", {31'd0, mem_req}, 32'd0);
        end
        mem_ack = 0; ir_taken = 0;
        check("halt.cnt_frozen", {16'd0, fetch_cnt}, 32'd8);

        // Reset out of halt, then reset again mid-request with ack asserted.
        rst_f = 1;
        step();
        rst_f = 0;
        step();
        check("rearm.mem_req", {31'd0, mem_req}, 32'd1);
        check("rearm.halted", {31'd0, halted}, 32'd0);
        mem_ack = 1; mem_rdata = 32'h7000_0000; rst_f = 1;
        #1;
        check("midrst.mem_req", {31'd0, mem_req}, 32'd0);
        step(); step();
        check("midrst.fetch_cnt", {16'd0, fetch_cnt}, 32'd0);
        check("midrst.ir", ir, 32'd0);
        check("midrst.ir_valid", {31'd0, ir_valid}, 32'd0);
        rst_f = 0;
        step();
        check("post.fetch_cnt", {16'd0, fetch_cnt}, 32'd0);
        check("post.mem_req", {31'd0, mem_req}, 32'd1);
        check("post.mem_addr", {16'd0, mem_addr}, 32'h0000);
        step();
        mem_ack = 0;
        check("post.ir", ir, 32'h7000_0000);
        check("post.fetch_cnt1", {16'd0, fetch_cnt}, 32'd1);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
